// File: rtl/pin_conditioner.sv
// pin_conditioner
//   Per-pin conditioning of raw asynchronous inputs such as buttons and switches.
//   Each pin passes through a two-flop synchronizer and then a debouncer.
//   Registered strobes report debounced edges and long presses.
//
// Parameters
//   PIN_NUM         number of independent pins
//   DEBOUNCE_CYCLES stable cycles needed to accept a new level (>= 2)
//   LONG_CYCLES     high-hold length that flags a long press (>= 1)
//   INIT_LEVEL      per-pin reset level of the synchronizer and pin_out
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   pin_in      raw asynchronous pins
//   pin_out     debounced level
//   rise_pulse  one-cycle strobe on a debounced 0->1
//   fall_pulse  one-cycle strobe on a debounced 1->0
//   long_press  one-cycle strobe when a high hold reaches LONG_CYCLES
//   held        high while a long press is in progress
module pin_conditioner #(
    parameter int unsigned        PIN_NUM         = 2,
    parameter int unsigned        DEBOUNCE_CYCLES = 750000,
    parameter int unsigned        LONG_CYCLES     = 75000000,
    parameter logic [PIN_NUM-1:0] INIT_LEVEL      = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIN_NUM-1:0] pin_in,
    output logic [PIN_NUM-1:0] pin_out,
    output logic [PIN_NUM-1:0] rise_pulse,
    output logic [PIN_NUM-1:0] fall_pulse,
    output logic [PIN_NUM-1:0] long_press,
    output logic [PIN_NUM-1:0] held
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [PIN_NUM-1:0] sync1_q;
    logic [PIN_NUM-1:0] sync2_q;
    logic [PIN_NUM-1:0] pin_out_q, pin_out_d;
    logic [PIN_NUM-1:0] rise_q, rise_d;
    logic [PIN_NUM-1:0] fall_q, fall_d;
    logic [PIN_NUM-1:0] long_q, long_d;
    logic [PIN_NUM-1:0] held_q, held_d;

    logic [DW-1:0] deb_cnt_q  [PIN_NUM];
    logic [DW-1:0] deb_cnt_d  [PIN_NUM];
    logic [HW-1:0] hold_cnt_q [PIN_NUM];
    logic [HW-1:0] hold_cnt_d [PIN_NUM];

    always_comb begin
        pin_out_d = pin_out_q;
        rise_d    = '0;
        fall_d    = '0;
        long_d    = '0;
        held_d    = '0;
        for (int unsigned i = 0; i < PIN_NUM; i++) begin
            deb_cnt_d[i]  = '0;
            hold_cnt_d[i] = '0;
        end

        for (int unsigned i = 0; i < PIN_NUM; i++) begin
            // Debounce: any cycle where the synchronized level matches pin_out
            // restarts the count, so bounces never accumulate.
            if (sync2_q[i] != pin_out_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    pin_out_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
                end
            end

            rise_d[i] = pin_out_d[i] & ~pin_out_q[i];
            fall_d[i] = ~pin_out_d[i] & pin_out_q[i];

            // Hold counting follows the registered level and saturates, so
            // long_press can fire only once per high period.
            if (pin_out_q[i]) begin
                if (hold_cnt_q[i] == HOLD_MAX) begin
                    hold_cnt_d[i] = hold_cnt_q[i];
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
                end
            end

            long_d[i] = pin_out_q[i] & (hold_cnt_q[i] == HOLD_LAST);
            // held drops together with pin_out, i.e. in the fall_pulse cycle.
            held_d[i] = pin_out_d[i] & (held_q[i] | long_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= INIT_LEVEL;
            sync2_q   <= INIT_LEVEL;
            pin_out_q <= INIT_LEVEL;
            rise_q    <= '0;
            fall_q    <= '0;
            long_q    <= '0;
            held_q    <= '0;
            for (int unsigned i = 0; i < PIN_NUM; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= pin_in;
            sync2_q   <= sync1_q;
            pin_out_q <= pin_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            long_q    <= long_d;
            held_q    <= held_d;
            for (int unsigned i = 0; i < PIN_NUM; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign pin_out    = pin_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign long_press = long_q;
    assign held       = held_q;

endmodule

// File: tb/tb_pin_conditioner.sv
// tb_pin_conditioner
//   Directed bench for pin_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=10,
//   PIN_NUM=2.  A second instance with INIT_LEVEL=2'b01 and its pin tied high
//   shares the reset and covers reset-level behaviour.
module tb_pin_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] pin_in;
    logic [1:0] pin_out, rise_pulse, fall_pulse, long_press, held;

    logic [1:0] pin_in2;
    logic [1:0] pin_out2, rise_pulse2, fall_pulse2, long_press2, held2;

    int unsigned n_checks;
    int unsigned n_fail;

    pin_conditioner #(
        .PIN_NUM        (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10),
        .INIT_LEVEL     (2'b00)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .long_press(long_press),
        .held      (held)
    );

    pin_conditioner #(
        .PIN_NUM        (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10),
        .INIT_LEVEL     (2'b01)
    ) u_dut_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_in    (pin_in2),
        .pin_out   (pin_out2),
        .rise_pulse(rise_pulse2),
        .fall_pulse(fall_pulse2),
        .long_press(long_press2),
        .held      (held2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [1:0]  pin;
        int unsigned n;     // cycles this record is applied
        logic [1:0]  out;
        logic [1:0]  rise;
        logic [1:0]  fall;
        logic [1:0]  lp;
        logic [1:0]  hd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] p, input int unsigned n,
                       input logic [1:0] o, input logic [1:0] ri, input logic [1:0] fa,
                       input logic [1:0] lp, input logic [1:0] hd);
        vec_t v;
        v.rst_n = r; v.pin = p; v.n = n;
        v.out = o; v.rise = ri; v.fall = fa; v.lp = lp; v.hd = hd;
        tbl.push_back(v);
    endtask

    // Drive inputs, advance one rising edge, then settle before sampling.
    task automatic step(input logic r, input logic [1:0] p);
        rst_n  = r;
        pin_in = p;
        @(posedge clk);
        #1;
    endtask

    // Compared bundle order: {pin_out, rise, fall, long, held}
    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual {out,rise,fall,long,held}=%b required %b", name, act, exp);
        end
    endtask

    int unsigned rise_cnt;
    logic [1:0]  e_out, e_rise, e_fall, e_lp, e_hd;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pin_in   = 2'b00;
        pin_in2  = 2'b01;

        // ---------------- table-driven vectors ----------------
        //   rst   pin    n   out    rise   fall   long   held
        add(1'b0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // reset state
        // clean press on pin0, held for a long press (out high 15 cycles)
        add(1'b1, 2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00); // 6th edge
        add(1'b1, 2'b01, 9, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01); // 10 after rise
        add(1'b1, 2'b00, 4, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        add(1'b1, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00); // release
        add(1'b1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // short press: out high 8 cycles
        add(1'b1, 2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b00, 5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add(1'b1, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // both pins together
        add(1'b1, 2'b11, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b11, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b00, 5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        add(1'b1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        @(negedge clk);
        foreach (tbl[i]) begin
            for (int unsigned c = 0; c < tbl[i].n; c++) begin
                step(tbl[i].rst_n, tbl[i].pin);
                check($sformatf("table[%0d].cyc%0d", i, c),
                      {pin_out, rise_pulse, fall_pulse, long_press, held},
                      {tbl[i].out, tbl[i].rise, tbl[i].fall, tbl[i].lp, tbl[i].hd});
            end
        end

        // ---------------- bounce on pin0 ----------------
        // High 3 cycles, low 1, then high; the low lands right before the
        // counter would have accepted, so acceptance restarts from zero.
        rise_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, ((k < 3) || (k >= 4 && k < 13)) ? 2'b01 : 2'b00);
            e_out  = (k >= 9 && k < 18) ? 2'b01 : 2'b00;
            e_rise = (k == 9)  ? 2'b01 : 2'b00;
            e_fall = (k == 18) ? 2'b01 : 2'b00;
            if (rise_pulse[0]) rise_cnt++;
            check($sformatf("bounce.cyc%0d", k),
                  {pin_out, rise_pulse, fall_pulse, long_press, held},
                  {e_out, e_rise, e_fall, 2'b00, 2'b00});
        end
        n_checks++;
        if (rise_cnt != 1) begin
            n_fail++;
            $display("FAIL bounce.rise_count: actual %0d required 1", rise_cnt);
        end

        // ---------------- reset in the middle of a hold ----------------
        // Reset at hold count 7; pin stays high so it re-debounces afterwards.
        for (int k = 0; k < 38; k++) begin
            step((k == 13) ? 1'b0 : 1'b1, (k < 31) ? 2'b01 : 2'b00);
            e_out  = ((k >= 5 && k <= 12) || (k >= 19 && k <= 35)) ? 2'b01 : 2'b00;
            e_rise = (k == 5 || k == 19) ? 2'b01 : 2'b00;
            e_fall = (k == 36) ? 2'b01 : 2'b00;
            e_lp   = (k == 29) ? 2'b01 : 2'b00;
            e_hd   = (k >= 29 && k <= 35) ? 2'b01 : 2'b00;
            check($sformatf("rst_mid.cyc%0d", k),
                  {pin_out, rise_pulse, fall_pulse, long_press, held},
                  {e_out, e_rise, e_fall, e_lp, e_hd});
            if (k >= 13) begin
                // INIT_LEVEL=1 instance: high right out of reset, hold counts at once
                e_lp = (k == 23) ? 2'b01 : 2'b00;
                e_hd = (k >= 23) ? 2'b01 : 2'b00;
                check($sformatf("init_hi.cyc%0d", k),
                      {pin_out2, rise_pulse2, fall_pulse2, long_press2, held2},
                      {2'b01, 2'b00, 2'b00, e_lp, e_hd});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_conditioner.md
PIN_CONDITIONER -- requirements
Module: pin_conditioner

Interface
REQ-001 SHALL have parameter PIN_NUM, default 2: number of independent input pins.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 750000: consecutive stable cycles needed to accept a new level (10 ms at 75 MHz); legal range >= 2.
REQ-003 SHALL have parameter LONG_CYCLES, default 75000000: cycles pin_out must stay high to flag a long press (1 s at 75 MHz); legal range >= 1.
REQ-004 SHALL have parameter INIT_LEVEL, width PIN_NUM, default all 0: per-pin reset value of the synchronizer and pin_out.
REQ-005 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-007 SHALL have port pin_in  input  PIN_NUM: raw asynchronous pins, such as buttons and switches.
REQ-008 SHALL have port pin_out  output  PIN_NUM: debounced level.
REQ-009 SHALL have port rise_pulse  output  PIN_NUM: one-cycle strobe on a debounced 0->1 transition.
REQ-010 SHALL have port fall_pulse  output  PIN_NUM: one-cycle strobe on a debounced 1->0 transition.
REQ-011 SHALL have port long_press  output  PIN_NUM: one-cycle strobe when a high hold reaches LONG_CYCLES.
REQ-012 SHALL have port held  output  PIN_NUM: level that is high while a long press is in progress.

Function
REQ-013 Each pin SHALL pass through a two-flop synchronizer (sync1 -> sync2) before any other logic; pins SHALL be fully independent.
REQ-014 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES); hold counter width SHALL be $clog2(LONG_CYCLES+1).
REQ-015 While sync2 == pin_out, the debounce counter SHALL be cleared to 0 every cycle.
REQ-016 While sync2 != pin_out and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 While sync2 != pin_out and the counter equals DEBOUNCE_CYCLES-1, the next edge SHALL load pin_out <= sync2 and clear the counter.
REQ-018 Latency: a clean level change on pin_in SHALL appear on pin_out on the (DEBOUNCE_CYCLES+2)-th rising edge, counting the first edge that samples the new level.
REQ-019 A glitch or bounce returning to the pin_out level before acceptance SHALL clear the counter; pin_out and the strobes SHALL not change.
REQ-020 rise_pulse/fall_pulse SHALL be registered and high for exactly the first cycle in which pin_out holds its new value, and low otherwise.
REQ-021 Hold counter: cleared while pin_out == 0; increments while pin_out == 1; saturates at LONG_CYCLES and never wraps.
REQ-022 long_press SHALL pulse high for one cycle on the edge where the hold counter goes from LONG_CYCLES-1 to LONG_CYCLES; it SHALL fire at most once per high period.
REQ-023 held SHALL rise in the same cycle as long_press, stay high while pin_out == 1, and fall in the same cycle that fall_pulse asserts.
REQ-024 A press released before LONG_CYCLES SHALL produce rise_pulse and fall_pulse only, with no long_press and no held.
REQ-025 Simultaneous transitions on several pins SHALL each produce their own strobes in the same cycle, with no arbitration.

Reset
REQ-026 With rst_n == 0 at a rising edge, for every pin: sync1, sync2 and pin_out SHALL load INIT_LEVEL; both counters SHALL load 0; rise_pulse, fall_pulse, long_press and held SHALL load 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort that operation, and no strobe SHALL be emitted for it.
REQ-028 After reset release, a pin level differing from INIT_LEVEL SHALL go through the normal debounce and then emit the matching strobe.
REQ-029 After reset release, a pin with INIT_LEVEL=1 that is held high SHALL start hold counting immediately.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, PIN_NUM=2, INIT_LEVEL=0)
REQ-030 Clean press: pin_in[0] 0->1 held -> pin_out[0]=1 on the 6th edge; rise_pulse[0]=1 for that one cycle; pin_out[1] and all pin-1 strobes stay 0.
REQ-031 Bounce: pin_in[0] high for 3 synchronized cycles, low for 1, then high steady -> pin_out[0] stays 0 during the bounce; it rises 6 edges after the final 0->1; exactly one rise_pulse.
REQ-032 Long press: pin_out[0] high for 15 cycles -> long_press[0] pulses once, 10 cycles after the rise; held[0]=1 until release; on release, fall_pulse[0] and held[0]=0 occur in the same cycle.
REQ-033 Short press: pin_out[0] high for 8 cycles -> one rise_pulse and one fall_pulse; long_press[0] and held[0] stay 0.
REQ-034 Reset mid-operation: rst_n=0 for 1 cycle at hold count 7 -> all outputs 0 on the next edge; with pin still high, re-debounce, then rise_pulse; long_press fires 10 cycles after the new rise.
REQ-035 Both pins change on the same edge -> rise_pulse=2'b11 in the same cycle; a back-to-back release gives fall_pulse=2'b11.
